// File: rtl/serial_mem_arbiter.sv
// serial_mem_arbiter
// Shares the bit-serial memory port between the instruction fetch (req0,
// read-only) and the load/store unit (req1, read or write). Round-robin
// arbitration picks a requester in IDLE. The address and, for writes, the
// write data are then shifted out LSB beat first. Read data is collected
// from the memory controller. One response pulse is returned per request.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   req0_valid/addr/ready     fetch request; ready is a 1-cycle grant pulse
//   req1_valid/we/addr/wdata  LSU request; req1_ready is a 1-cycle grant pulse
//   rsp0_valid, rsp1_valid    1-cycle response pulse to the granted requester
//   rsp_rdata, rsp_err        read data / read-timeout flag, valid with rsp*
//   mem_serial_data           current beat (0 when no beat is being shifted)
//   mem_shift_en              beat valid
//   mem_transaction_done      beat strobe, identical to mem_shift_en
//   mem_read_write            1=write, 0=read, stable for the whole transaction
//   mem_rd_valid, mem_rd_data read return from memory (used only in WAIT_RD)
//   busy                      high whenever not IDLE
module serial_mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int BEAT_W     = 8,
  parameter int RD_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  input  logic [AW-1:0]     req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [AW-1:0]     req1_addr,
  input  logic [DW-1:0]     req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  output logic [BEAT_W-1:0] mem_serial_data,
  output logic              mem_shift_en,
  output logic              mem_transaction_done,
  output logic              mem_read_write,
  input  logic              mem_rd_valid,
  input  logic [DW-1:0]     mem_rd_data,
  output logic              busy
);

  localparam int ABEATS = AW / BEAT_W;
  localparam int DBEATS = DW / BEAT_W;
  localparam int MAXB   = (ABEATS > DBEATS) ? ABEATS : DBEATS;
  localparam int BCW    = $clog2(MAXB + 1);
  localparam int TCW    = $clog2(RD_TIMEOUT + 1);
  localparam logic [BCW-1:0] A_LAST  = BCW'(ABEATS - 1);
  localparam logic [BCW-1:0] D_LAST  = BCW'(DBEATS - 1);
  localparam logic [TCW-1:0] TO_LAST = TCW'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, WR_COMMIT, WAIT_RD, RESP
  } state_t;

  state_t           state, state_nxt;
  logic [BCW-1:0]   beat_cnt;
  logic [TCW-1:0]   to_cnt;
  logic             last_grant;  // also identifies the requester being served
  logic             we_q;
  logic             err_q;
  logic [AW+DW-1:0] sr;          // {wdata, addr}, shifted right one beat per strobe
  logic [DW-1:0]    rdata_q;

  logic grant0, grant1, last_beat, rd_timeout;

  // On a tie the requester that was not served last wins.
  assign grant0 = req0_valid && (!req1_valid || last_grant);
  assign grant1 = req1_valid && (!req0_valid || !last_grant);

  assign last_beat  = ((state == ADDR) && (beat_cnt == A_LAST)) ||
                      ((state == DATA) && (beat_cnt == D_LAST));
  assign rd_timeout = !mem_rd_valid && (to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    mem_shift_en = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    case (state)
      IDLE: begin
        // Ready is combinational on valid, so it is masked while reset is
        // held to keep every output low during reset.
        req0_ready = grant0 && reset_n;
        req1_ready = grant1 && reset_n;
        if (grant0 || grant1) state_nxt = ADDR;
      end
      ADDR: begin
        mem_shift_en = 1'b1;
        if (last_beat) state_nxt = we_q ? DATA : WAIT_RD;
      end
      DATA: begin
        mem_shift_en = 1'b1;
        if (last_beat) state_nxt = WR_COMMIT;
      end
      WR_COMMIT: state_nxt = RESP;
      WAIT_RD: begin
        if (mem_rd_valid || rd_timeout) state_nxt = RESP;
      end
      RESP: begin
        rsp0_valid = !last_grant;
        rsp1_valid = last_grant;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_transaction_done = mem_shift_en;
  assign mem_serial_data      = mem_shift_en ? sr[BEAT_W-1:0] : '0;
  assign busy                 = (state != IDLE);
  assign mem_read_write       = busy && we_q;
  assign rsp_rdata            = (state == RESP) ? rdata_q : '0;
  assign rsp_err              = (state == RESP) && err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_cnt   <= '0;
      to_cnt     <= '0;
      last_grant <= 1'b1;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            last_grant <= grant1;
            we_q       <= grant1 && req1_we;
            err_q      <= 1'b0;
            beat_cnt   <= '0;
            to_cnt     <= '0;
          end
        end
        ADDR, DATA: beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        WAIT_RD: begin
          to_cnt <= to_cnt + 1'b1;
          if (rd_timeout) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Payload registers carry no reset: every output they feed is gated by state.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (grant1)      sr <= {req1_wdata, req1_addr};
        else if (grant0) sr <= {{DW{1'b0}}, req0_addr};
        rdata_q <= '0;  // writes and timed-out reads respond with zero
      end
      ADDR, DATA: sr <= sr >> BEAT_W;
      WAIT_RD: if (mem_rd_valid) rdata_q <= mem_rd_data;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_serial_mem_arbiter.sv
module tb_serial_mem_arbiter;
  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int BEAT_W     = 8;
  localparam int RD_TIMEOUT = 15;
  localparam int NA         = AW / BEAT_W;
  localparam int ND         = DW / BEAT_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req0_valid = 1'b0;
  logic [AW-1:0]     req0_addr = '0;
  logic              req0_ready;
  logic              req1_valid = 1'b0;
  logic              req1_we = 1'b0;
  logic [AW-1:0]     req1_addr = '0;
  logic [DW-1:0]     req1_wdata = '0;
  logic              req1_ready;
  logic              rsp0_valid, rsp1_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err;
  logic [BEAT_W-1:0] mem_serial_data;
  logic              mem_shift_en, mem_transaction_done, mem_read_write;
  logic              mem_rd_valid = 1'b0;
  logic [DW-1:0]     mem_rd_data = '0;
  logic              busy;

  serial_mem_arbiter #(.AW(AW), .DW(DW), .BEAT_W(BEAT_W), .RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_serial_data(mem_serial_data), .mem_shift_en(mem_shift_en),
    .mem_transaction_done(mem_transaction_done), .mem_read_write(mem_read_write),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: pending requests and who was served last.
  logic [AW-1:0] p_addr [2];
  logic [DW-1:0] p_wdata;
  logic          p_we;
  bit            pend [2];
  int            m_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    req0_valid = pend[0];
    req0_addr  = p_addr[0];
    req1_valid = pend[1];
    req1_addr  = p_addr[1];
    req1_we    = p_we;
    req1_wdata = p_wdata;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy0"}, req0_ready, 0);
    check({tag, "_rdy1"}, req1_ready, 0);
    check({tag, "_rsp0"}, rsp0_valid, 0);
    check({tag, "_rsp1"}, rsp1_valid, 0);
    check({tag, "_rdata"}, rsp_rdata, 0);
    check({tag, "_err"}, rsp_err, 0);
    check({tag, "_shift"}, mem_shift_en, 0);
    check({tag, "_done"}, mem_transaction_done, 0);
    check({tag, "_sdata"}, mem_serial_data, 0);
    check({tag, "_rw"}, mem_read_write, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    pend[0] = 0;
    pend[1] = 0;
    drive_reqs();
    mem_rd_valid = 1'b0;
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    m_last = 1;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    drive_reqs();
    mem_rd_valid = 1'($urandom_range(0, 1));
    mem_rd_data  = $urandom;
    #1;
    check_all_zero("idle");
  endtask

  // One complete transaction starting in IDLE. lat is the WAIT_RD cycle index
  // at which memory returns data; lat >= RD_TIMEOUT means it never does.
  task automatic run_txn(input int lat, input logic [DW-1:0] rdat, input bit noise);
    int            w;
    logic          we;
    logic [AW-1:0] a, ta;
    logic [DW-1:0] d, td, exp_rd;
    logic          exp_err;
    @(negedge clk);
    drive_reqs();
    mem_rd_valid = 1'b0;
    #1;
    if (pend[0] && pend[1]) w = (m_last == 1) ? 0 : 1;
    else                    w = pend[1] ? 1 : 0;
    check("grant_rdy0", req0_ready, w == 0);
    check("grant_rdy1", req1_ready, w == 1);
    check("grant_busy", busy, 0);
    check("grant_shift", mem_shift_en, 0);
    m_last = w;
    we = (w == 1) && p_we;
    a  = p_addr[w];
    d  = p_wdata;
    pend[w] = 0;
    for (int k = 0; k < NA; k++) begin
      @(negedge clk);
      drive_reqs();
      mem_rd_valid = noise && (k == 1);
      mem_rd_data  = $urandom;
      #1;
      ta = a >> (BEAT_W * k);
      check("addr_beat", mem_serial_data, ta[BEAT_W-1:0]);
      check("addr_shift", mem_shift_en, 1);
      check("addr_done", mem_transaction_done, 1);
      check("addr_rw", mem_read_write, we);
      check("addr_busy", busy, 1);
      check("addr_rdy", {req0_ready, req1_ready}, 0);
      check("addr_rsp", {rsp0_valid, rsp1_valid}, 0);
    end
    mem_rd_valid = 1'b0;
    if (we) begin
      for (int k = 0; k < ND; k++) begin
        @(negedge clk);
        drive_reqs();
        #1;
        td = d >> (BEAT_W * k);
        check("data_beat", mem_serial_data, td[BEAT_W-1:0]);
        check("data_shift", mem_shift_en, 1);
        check("data_done", mem_transaction_done, 1);
        check("data_rw", mem_read_write, 1);
        check("data_rsp", {rsp0_valid, rsp1_valid}, 0);
      end
      @(negedge clk);
      drive_reqs();
      #1;
      check("commit_shift", mem_shift_en, 0);
      check("commit_sdata", mem_serial_data, 0);
      check("commit_busy", busy, 1);
      check("commit_rsp", {rsp0_valid, rsp1_valid}, 0);
      exp_rd  = '0;
      exp_err = 1'b0;
    end else begin
      exp_rd  = (lat < RD_TIMEOUT) ? rdat : '0;
      exp_err = (lat >= RD_TIMEOUT);
      for (int i = 0; i < RD_TIMEOUT; i++) begin
        @(negedge clk);
        drive_reqs();
        mem_rd_valid = (i == lat);
        mem_rd_data  = (i == lat) ? rdat : $urandom;
        #1;
        check("wait_shift", mem_shift_en, 0);
        check("wait_sdata", mem_serial_data, 0);
        check("wait_busy", busy, 1);
        check("wait_rw", mem_read_write, 0);
        check("wait_rsp", {rsp0_valid, rsp1_valid}, 0);
        if (i == lat) break;
      end
    end
    @(negedge clk);
    drive_reqs();
    mem_rd_valid = 1'b0;
    mem_rd_data  = $urandom;
    #1;
    check("rsp0", rsp0_valid, w == 0);
    check("rsp1", rsp1_valid, w == 1);
    check("rsp_rdata", rsp_rdata, exp_rd);
    check("rsp_err", rsp_err, exp_err);
    check("rsp_busy", busy, 1);
    check("rsp_shift", mem_shift_en, 0);
    check("rsp_rw", mem_read_write, we);
    check("rsp_rdy", {req0_ready, req1_ready}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    p_addr[0] = '0;
    p_addr[1] = '0;
    p_wdata   = '0;
    p_we      = 1'b0;
    do_reset();

    // Fetch read, data returned two cycles after the last address beat.
    pend[0] = 1; p_addr[0] = 32'h0000_1004;
    run_txn(1, 32'hDEAD_BEEF, 0);

    // LSU write.
    pend[1] = 1; p_we = 1'b1; p_addr[1] = 32'h20; p_wdata = 32'hA5A5_1234;
    run_txn(0, '0, 0);

    // Both requesters held across three transactions after reset.
    do_reset();
    pend[0] = 1; p_addr[0] = 32'h0000_0100;
    pend[1] = 1; p_addr[1] = 32'h0000_0200; p_we = 1'b0;
    for (int t = 0; t < 3; t++) begin
      run_txn(2, $urandom, 0);
      pend[0] = 1;
      pend[1] = 1;
    end
    pend[0] = 0;
    pend[1] = 0;

    // Read timeout, then a normal read.
    pend[0] = 1; p_addr[0] = $urandom;
    run_txn(RD_TIMEOUT, '0, 0);
    pend[1] = 1; p_we = 1'b0; p_addr[1] = $urandom;
    run_txn(3, 32'h1234_5678, 0);

    // Stray read-valid during the address phase.
    pend[0] = 1; p_addr[0] = $urandom;
    run_txn(4, $urandom, 1);

    // Reset during the second write-data beat; req1 stays pending.
    do_reset();
    pend[1] = 1; p_we = 1'b1; p_addr[1] = $urandom; p_wdata = $urandom;
    @(negedge clk);
    drive_reqs();
    #1;
    check("abort_grant", req1_ready, 1);
    for (int k = 0; k < NA + 2; k++) begin
      @(negedge clk);
      drive_reqs();
      #1;
    end
    check("abort_pre_shift", mem_shift_en, 1);
    check("abort_pre_beat", mem_serial_data, p_wdata[2*BEAT_W-1:BEAT_W]);
    reset_n = 1'b0;
    #1;
    check_all_zero("abort");
    @(posedge clk);
    @(posedge clk);
    #1;
    check_all_zero("abort_hold");
    #1 reset_n = 1'b1;
    m_last = 1;
    run_txn(0, '0, 0);

    // Randomized traffic.
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < 2; r++) begin
        if (!pend[r] && ($urandom_range(0, 2) != 0)) begin
          pend[r]   = 1;
          p_addr[r] = $urandom;
          if (r == 1) begin
            p_we    = 1'($urandom_range(0, 1));
            p_wdata = $urandom;
          end
        end
      end
      if (!pend[0] && !pend[1]) idle_cycle();
      else run_txn($urandom_range(0, RD_TIMEOUT + 2), $urandom, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
